// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing the UART host register port among NUM_REQ requesters.
// Optional macro UART_ARB_IRQ_PRIORITY_EN: requester 0 wins while ireq_n_i is low.
module uart_bus_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int ACCESS_CYCLES = 2,
   parameter int GAP_CYCLES    = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NUM_REQ-1:0]   req_i,
   input  logic [NUM_REQ-1:0]   we_i,
   input  logic [3*NUM_REQ-1:0] addr_i,
   input  logic [8*NUM_REQ-1:0] wdata_i,
   output logic [NUM_REQ-1:0]   gnt_o,
   output logic [NUM_REQ-1:0]   done_o,
   output logic [7:0]           rdata_o,
   output logic                 chip_sel_n_o,
   output logic [2:0]           address_o,
   output logic                 read_write_o,
   output logic [7:0]           data_o,
   output logic                 data_oe_o,
   input  logic [7:0]           data_i,
   input  logic                 ireq_n_i
);
   localparam int IW   = $clog2(NUM_REQ);
   localparam int MAXW = (ACCESS_CYCLES > GAP_CYCLES) ? ACCESS_CYCLES : GAP_CYCLES;
   localparam int CW   = $clog2(MAXW + 1);
   localparam logic [CW-1:0] ACC_LOAD = CW'(ACCESS_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, GAP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] last_grant;
   logic [IW-1:0] win;
   logic [IW-1:0] pick_idx;
   logic [IW-1:0] cand_idx;
   logic          found;
   logic          sel_we;
   logic [2:0]    sel_addr;
   logic [7:0]    sel_wdata;

`ifndef UART_ARB_IRQ_PRIORITY_EN
   logic unused_ireq;
   assign unused_ireq = ireq_n_i;
`endif

   // Round-robin winner search, starting one past the last granted requester
   always_comb begin
      int cand;
      cand     = 0;
      cand_idx = '0;
      found    = 1'b0;
      pick_idx = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = int'(last_grant) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end else begin
            cand = cand;
         end
         cand_idx = IW'(cand);
         if (!found && req_i[cand_idx]) begin
            found    = 1'b1;
            pick_idx = cand_idx;
         end else begin
            found    = found;
         end
      end
`ifdef UART_ARB_IRQ_PRIORITY_EN
      if (!ireq_n_i && req_i[0]) begin
         found    = 1'b1;
         pick_idx = '0;
      end else begin
         pick_idx = pick_idx;
      end
`endif
      sel_we    = we_i[pick_idx];
      sel_addr  = addr_i[int'(pick_idx)*3 +: 3];
      sel_wdata = wdata_i[int'(pick_idx)*8 +: 8];
   end

   // Sequencer FSM; every bus-facing output is a flop
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         cnt          <= '0;
         last_grant   <= IW'(NUM_REQ - 1);
         win          <= '0;
         gnt_o        <= '0;
         done_o       <= '0;
         rdata_o      <= 8'h00;
         chip_sel_n_o <= 1'b1;
         address_o    <= 3'd0;
         read_write_o <= 1'b1;
         data_o       <= 8'h00;
         data_oe_o    <= 1'b0;
      end else begin
         done_o <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  state        <= SETUP;
                  win          <= pick_idx;
                  gnt_o        <= ONE_HOT0 << pick_idx;
                  address_o    <= sel_addr;
                  read_write_o <= ~sel_we;
                  data_o       <= sel_wdata;
                  data_oe_o    <= sel_we;
               end
            end
            SETUP: begin
               state        <= ACCESS;
               chip_sel_n_o <= 1'b0;
               cnt          <= ACC_LOAD;
            end
            ACCESS: begin
               if (cnt == '0) begin
                  state        <= GAP;
                  chip_sel_n_o <= 1'b1;
                  gnt_o        <= '0;
                  data_oe_o    <= 1'b0;
                  done_o       <= gnt_o;
                  last_grant   <= win;
                  cnt          <= GAP_LOAD;
                  if (read_write_o) begin
                     rdata_o <= data_i;
                  end
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            GAP: begin
               // address and direction stay parked until the gap has elapsed
               if (cnt == '0) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Scoreboard bench for uart_bus_arbiter: stimulus pushes expected accesses, a negedge monitor checks them.
module tb_uart_bus_arbiter;
   localparam int NREQ = 4;
   localparam int ACC  = 2;
   localparam int GAPC = 1;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic [NREQ-1:0]  req_i = '0;
   logic [NREQ-1:0]  we_i = '0;
   logic [3*NREQ-1:0] addr_i = '0;
   logic [8*NREQ-1:0] wdata_i = '0;
   logic [NREQ-1:0]  gnt_o;
   logic [NREQ-1:0]  done_o;
   logic [7:0]       rdata_o;
   logic             chip_sel_n_o;
   logic [2:0]       address_o;
   logic             read_write_o;
   logic [7:0]       data_o;
   logic             data_oe_o;
   logic [7:0]       data_i = 8'h00;
   logic             ireq_n_i = 1'b1;

   uart_bus_arbiter #(.NUM_REQ(NREQ), .ACCESS_CYCLES(ACC), .GAP_CYCLES(GAPC)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o),
      .chip_sel_n_o(chip_sel_n_o), .address_o(address_o), .read_write_o(read_write_o),
      .data_o(data_o), .data_oe_o(data_oe_o), .data_i(data_i), .ireq_n_i(ireq_n_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int         idx;
      logic       we;
      logic [2:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
   } exp_t;

   exp_t exp_gnt[$];
   exp_t exp_done[$];
   int   setup_log[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   exp_t cur;
   int   cur_setup = 0;
   int   cs_low = 0;
   int   cs_high = 0;
   logic seen_low = 1'b0;
   logic [NREQ-1:0] prev_gnt = '0;
   logic [7:0] last_rd = 8'h00;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [NREQ-1:0] onehot(input int idx);
      logic [NREQ-1:0] one;
      one = {{(NREQ-1){1'b0}}, 1'b1};
      return one << idx;
   endfunction

   // Monitor: checks SETUP, ACCESS window and completion against the scoreboard
   always @(negedge clk_i) begin
      exp_t e;
      if (rst_i) begin
         cs_low   = 0;
         cs_high  = 0;
         seen_low = 1'b0;
         prev_gnt = '0;
      end else begin
         if (gnt_o != '0 && prev_gnt == '0) begin
            setup_log.push_back(cyc);
            if (exp_gnt.size() == 0) begin
               chk("unexpected_grant", 32'(gnt_o), 32'd0);
            end else begin
               e = exp_gnt.pop_front();
               cur = e;
               cur_setup = cyc;
               chk("setup_bus", {chip_sel_n_o, gnt_o, address_o, read_write_o, data_oe_o, data_o},
                   {1'b1, onehot(e.idx), e.addr, ~e.we, e.we, e.wdata});
            end
         end
         if (!chip_sel_n_o) begin
            if (cs_low == 0 && seen_low) chk("cs_gap_len", 32'(cs_high >= GAPC + 2), 32'd1);
            cs_low++;
            cs_high = 0;
            chk("access_bus", {gnt_o, address_o, read_write_o, data_oe_o, data_o},
                {onehot(cur.idx), cur.addr, ~cur.we, cur.we, cur.wdata});
         end else begin
            if (cs_low != 0) begin
               chk("cs_low_len", 32'(cs_low), 32'(ACC));
               seen_low = 1'b1;
            end
            cs_low = 0;
            cs_high++;
         end
         if (done_o != '0) begin
            if (exp_done.size() == 0) begin
               chk("unexpected_done", 32'(done_o), 32'd0);
            end else begin
               e = exp_done.pop_front();
               if (!e.we) last_rd = e.rdata;
               chk("done_vec", 32'(done_o), 32'(onehot(e.idx)));
               chk("done_latency", 32'(cyc - cur_setup), 32'(ACC + 1));
               chk("done_rdata", 32'(rdata_o), 32'(last_rd));
               chk("done_bus", {gnt_o, chip_sel_n_o, data_oe_o}, {{NREQ{1'b0}}, 1'b1, 1'b0});
            end
         end
         prev_gnt = gnt_o;
      end
   end

   task automatic cfg(input int k, input logic we, input logic [2:0] a, input logic [7:0] wd);
      we_i[k] = we;
      addr_i[3*k +: 3] = a;
      wdata_i[8*k +: 8] = wd;
   endtask

   task automatic expect_acc(input int k, input logic we, input logic [2:0] a,
                             input logic [7:0] wd, input logic [7:0] rd);
      exp_t e;
      e.idx = k; e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd;
      exp_gnt.push_back(e);
      exp_done.push_back(e);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_gnt.size() != 0 || exp_done.size() != 0) && n < budget) begin
         @(posedge clk_i);
         n++;
      end
      if (exp_gnt.size() != 0 || exp_done.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: pending grants %0d, pending dones %0d", exp_gnt.size(), exp_done.size());
         exp_gnt.delete();
         exp_done.delete();
      end
      @(negedge clk_i);
      req_i = '0;
   endtask

   task automatic wait_cs_low(input int budget);
      int n;
      n = 0;
      while (chip_sel_n_o && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      chk("cs_low_seen", 32'(chip_sel_n_o), 32'd0);
   endtask

   initial begin
      int c;
      int n0;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_gnt", 32'(gnt_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_rdata", 32'(rdata_o), 32'd0);
      chk("rst_bus", {chip_sel_n_o, address_o, read_write_o, data_o, data_oe_o},
          {1'b1, 3'd0, 1'b1, 8'h00, 1'b0});

      // fairness: all four held high, pointer starts at NUM_REQ-1
      for (int k = 0; k < NREQ; k++) cfg(k, 1'b1, 3'(k + 1), 8'h10 + 8'(k));
      for (int k = 0; k < NREQ; k++) expect_acc(k, 1'b1, 3'(k + 1), 8'h10 + 8'(k), 8'h00);
      expect_acc(0, 1'b1, 3'd1, 8'h10, 8'h00);
      n0 = setup_log.size();
      @(negedge clk_i);
      req_i = 4'b1111;
      c = cyc;
      drain(100);
      chk("fair_count", 32'(setup_log.size() - n0), 32'd5);
      if (setup_log.size() - n0 == 5) begin
         chk("fair_first", 32'(setup_log[n0]), 32'(c + 1));
         for (int i = 1; i < 5; i++) chk("fair_spacing", 32'(setup_log[n0+i] - setup_log[n0+i-1]), 32'd5);
      end

      // single write from requester 2
      cfg(2, 1'b1, 3'd5, 8'hA5);
      expect_acc(2, 1'b1, 3'd5, 8'hA5, 8'h00);
      n0 = setup_log.size();
      @(negedge clk_i);
      req_i = 4'b0100;
      c = cyc;
      drain(40);
      chk("wr_setup_cycle", 32'(setup_log[n0]), 32'(c + 1));

      // single read from requester 1
      cfg(1, 1'b0, 3'd0, 8'h00);
      data_i = 8'h3C;
      expect_acc(1, 1'b0, 3'd0, 8'h00, 8'h3C);
      @(negedge clk_i);
      req_i = 4'b0010;
      drain(40);
      data_i = 8'h99;
      repeat (3) @(negedge clk_i);
      chk("rdata_hold", 32'(rdata_o), 32'h3C);

      // pointer now at 1; interrupt request pending
      cfg(0, 1'b1, 3'd2, 8'h11);
      cfg(2, 1'b1, 3'd3, 8'h22);
      ireq_n_i = 1'b0;
`ifdef UART_ARB_IRQ_PRIORITY_EN
      expect_acc(0, 1'b1, 3'd2, 8'h11, 8'h00);
`else
      expect_acc(2, 1'b1, 3'd3, 8'h22, 8'h00);
`endif
      @(negedge clk_i);
      req_i = 4'b0101;
      drain(40);
      ireq_n_i = 1'b1;

      // requester 3 drops its request mid-access
      cfg(3, 1'b1, 3'd7, 8'h5A);
      expect_acc(3, 1'b1, 3'd7, 8'h5A, 8'h00);
      n0 = setup_log.size();
      @(negedge clk_i);
      req_i = 4'b1000;
      wait_cs_low(20);
      req_i = 4'b0000;
      drain(40);
      repeat (10) @(negedge clk_i);
      chk("drop_no_regrant", 32'(setup_log.size() - n0), 32'd1);

      // reset in the middle of a read
      cfg(1, 1'b0, 3'd4, 8'h00);
      data_i = 8'h77;
      expect_acc(1, 1'b0, 3'd4, 8'h00, 8'h77);
      @(negedge clk_i);
      req_i = 4'b0010;
      wait_cs_low(20);
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      #1;
      chk("midrst_bus", {gnt_o, done_o, chip_sel_n_o, data_oe_o, rdata_o},
          {{NREQ{1'b0}}, {NREQ{1'b0}}, 1'b1, 1'b0, 8'h00});
      exp_gnt.delete();
      exp_done.delete();
      last_rd = 8'h00;
      req_i = 4'b1111;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      expect_acc(0, 1'b1, 3'd2, 8'h11, 8'h00);
      drain(40);
      repeat (5) @(negedge clk_i);

      chk("queues_empty", 32'(exp_gnt.size() + exp_done.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
